// File: rtl/hs_pkg.sv
// Shared definitions for the two-requester hs arbiter.
// Provides the arbiter FSM state encoding, the read data returned
// with a timeout error, and the default timeout length in cycles.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } hs_state_t;

  // Read data returned to a requester whose transaction was aborted
  localparam int unsigned HS_ERR_DATA = 0;

  // Cycles a granted transaction may wait for the target before aborting
  localparam int unsigned HS_DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/hs_arbiter_2_rr_pick.sv
// Combinational round-robin selector for two requesters.
// Ports:
//   req         - request vector, bit k set when requester k wants the target
//   last_grant  - index of the requester granted most recently
//   grant_valid - at least one requester is asking
//   grant_idx   - index of the requester to grant (valid with grant_valid)
module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // A lone requester always wins; on a tie the one not served last time wins
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/hs_arbiter_2.sv
// Two-requester round-robin arbiter sharing one hs target.
// One transaction is in flight at a time; the grant is held until the
// target answers with s_ready_i, or until TIMEOUT cycles elapse, in which
// case the requester gets a ready pulse flagged with an error.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   m0_* / m1_*            - requester hs ports (read/write/addr/data in,
//                            ready/data/err out)
//   s_read_o .. s_data_o   - registered target request
//   s_ready_i, s_data_i    - target completion pulse and read data
module hs_arbiter_2
  import hs_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = HS_DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_read_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ready_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_err_o,
  input  logic              m1_read_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ready_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_err_o,
  output logic              s_read_o,
  output logic              s_write_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic              s_ready_i,
  input  logic [DATA_W-1:0] s_data_i
);

  // A zero TIMEOUT disables the counter, but it still needs a legal width
  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(HS_ERR_DATA);

  hs_state_t state, state_next;

  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic grant_valid;
  logic grant_idx;
  logic grant_take;
  logic strobe_clear;
  logic cnt_inc;
  logic done;
  logic abort;

  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_pick_2 u_pick (
    .req         ({m1_read_i | m1_write_i, m0_read_i | m0_write_i}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_read  = grant_idx ? m1_read_i  : m0_read_i;
  assign sel_write = grant_idx ? m1_write_i : m0_write_i;
  assign sel_addr  = grant_idx ? m1_addr_i  : m0_addr_i;
  assign sel_data  = grant_idx ? m1_data_i  : m0_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Completion takes priority over an expiring counter, so a target that
  // answers in the last allowed cycle still completes without error
  always_comb begin
    state_next   = state;
    grant_take   = 1'b0;
    strobe_clear = 1'b0;
    cnt_inc      = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          grant_take = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (s_ready_i) begin
          done         = 1'b1;
          strobe_clear = 1'b1;
          state_next   = IDLE;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          strobe_clear = 1'b1;
          state_next   = ABORT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ABORT: begin
        abort      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Requester responses are combinational so a target answering in the
  // same cycle is forwarded without an extra cycle of latency
  assign m0_ready_o = (done | abort) & ~grant;
  assign m1_ready_o = (done | abort) &  grant;
  assign m0_err_o   = abort & ~grant;
  assign m1_err_o   = abort &  grant;
  assign m0_data_o  = (done && !grant) ? s_data_i : ERR_DATA;
  assign m1_data_o  = (done &&  grant) ? s_data_i : ERR_DATA;

  // Target request registers; a write beats a read from the same master.
  // Address and data stay put after the strobe drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      s_read_o   <= 1'b0;
      s_write_o  <= 1'b0;
      s_addr_o   <= '0;
      s_data_o   <= '0;
    end else if (grant_take) begin
      grant      <= grant_idx;
      last_grant <= grant_idx;
      cnt        <= '0;
      s_read_o   <= sel_read & ~sel_write;
      s_write_o  <= sel_write;
      s_addr_o   <= sel_addr;
      s_data_o   <= sel_data;
    end else begin
      if (strobe_clear) begin
        s_read_o  <= 1'b0;
        s_write_o <= 1'b0;
      end
      if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hs_arbiter_2.sv
// Directed self-checking bench for hs_arbiter_2 (TIMEOUT = 8).
// Inputs are driven 1 ns after the rising edge; outputs are checked a few
// ns later, well before the next rising edge.
module tb_hs_arbiter_2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_read_i = 1'b0, m0_write_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_data_i = '0;
  logic        m0_ready_o, m0_err_o;
  logic [31:0] m0_data_o;
  logic        m1_read_i = 1'b0, m1_write_i = 1'b0;
  logic [31:0] m1_addr_i = '0, m1_data_i = '0;
  logic        m1_ready_o, m1_err_o;
  logic [31:0] m1_data_o;
  logic        s_read_o, s_write_o;
  logic [31:0] s_addr_o, s_data_o;
  logic        s_ready_i = 1'b0;
  logic [31:0] s_data_i = '0;

  int tests_run = 0;
  int tests_failed = 0;

  hs_arbiter_2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .m0_read_i  (m0_read_i),
    .m0_write_i (m0_write_i),
    .m0_addr_i  (m0_addr_i),
    .m0_data_i  (m0_data_i),
    .m0_ready_o (m0_ready_o),
    .m0_data_o  (m0_data_o),
    .m0_err_o   (m0_err_o),
    .m1_read_i  (m1_read_i),
    .m1_write_i (m1_write_i),
    .m1_addr_i  (m1_addr_i),
    .m1_data_i  (m1_data_i),
    .m1_ready_o (m1_ready_o),
    .m1_data_o  (m1_data_o),
    .m1_err_o   (m1_err_o),
    .s_read_o   (s_read_o),
    .s_write_o  (s_write_o),
    .s_addr_o   (s_addr_o),
    .s_data_o   (s_data_o),
    .s_ready_i  (s_ready_i),
    .s_data_i   (s_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic m0r, input logic m0w, input logic [31:0] m0a,
                               input logic [31:0] m0d, input logic m1r, input logic m1w,
                               input logic [31:0] m1a, input logic [31:0] m1d);
    m0_read_i  = m0r;
    m0_write_i = m0w;
    m0_addr_i  = m0a;
    m0_data_i  = m0d;
    m1_read_i  = m1r;
    m1_write_i = m1w;
    m1_addr_i  = m1a;
    m1_data_i  = m1d;
    #1;
  endtask

  task automatic setTarget(input logic rdy, input logic [31:0] d);
    s_ready_i = rdy;
    s_data_i  = d;
    #1;
  endtask

  logic [31:0] rd_vals [4];
  logic        gnt1;

  initial begin
    rd_vals = '{32'h11, 32'h22, 32'h33, 32'h44};

    // Reset state
    #1;
    checkOutput("rst s_read", 32'(s_read_o), 32'd0);
    checkOutput("rst s_write", 32'(s_write_o), 32'd0);
    checkOutput("rst s_addr", s_addr_o, 32'd0);
    checkOutput("rst m0_ready", 32'(m0_ready_o), 32'd0);
    checkOutput("rst m1_err", 32'(m1_err_o), 32'd0);
    waitCycle();
    waitCycle();
    rst_ni = 1'b1;

    // Both masters reading continuously: grants alternate starting at m0
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      waitCycle();
      gnt1 = (i % 2 == 1);
      checkOutput($sformatf("rr s_read[%0d]", i), 32'(s_read_o), 32'd1);
      checkOutput($sformatf("rr s_addr[%0d]", i), s_addr_o, gnt1 ? 32'h200 : 32'h100);
      setTarget(1'b1, rd_vals[i]);
      checkOutput($sformatf("rr m0_ready[%0d]", i), 32'(m0_ready_o), gnt1 ? 32'd0 : 32'd1);
      checkOutput($sformatf("rr m1_ready[%0d]", i), 32'(m1_ready_o), gnt1 ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr m0_data[%0d]", i), m0_data_o, gnt1 ? 32'd0 : rd_vals[i]);
      checkOutput($sformatf("rr m1_data[%0d]", i), m1_data_o, gnt1 ? rd_vals[i] : 32'd0);
      waitCycle();
      setTarget(1'b0, 32'h0);
      checkOutput($sformatf("rr idle s_read[%0d]", i), 32'(s_read_o), 32'd0);
      checkOutput($sformatf("rr idle m0_ready[%0d]", i), 32'(m0_ready_o), 32'd0);
    end

    // m0 write, target answers on the fourth strobe cycle
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0C, 32'hA5, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wr idle s_write", 32'(s_write_o), 32'd0);
    waitCycle();
    checkOutput("wr s_addr", s_addr_o, 32'h0C);
    checkOutput("wr s_data", s_data_o, 32'hA5);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("wr s_write[%0d]", k), 32'(s_write_o), 32'd1);
      checkOutput($sformatf("wr m0_ready early[%0d]", k), 32'(m0_ready_o), 32'd0);
      waitCycle();
    end
    setTarget(1'b1, 32'h0);
    checkOutput("wr m0_ready", 32'(m0_ready_o), 32'd1);
    checkOutput("wr m0_err", 32'(m0_err_o), 32'd0);
    checkOutput("wr m1_ready", 32'(m1_ready_o), 32'd0);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    setTarget(1'b0, 32'h0);
    checkOutput("wr done s_write", 32'(s_write_o), 32'd0);
    checkOutput("wr done m0_ready", 32'(m0_ready_o), 32'd0);

    // m1 read, target silent: eight strobe cycles then an abort
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    waitCycle();
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("to s_read[%0d]", k), 32'(s_read_o), 32'd1);
      checkOutput($sformatf("to m1_ready early[%0d]", k), 32'(m1_ready_o), 32'd0);
      waitCycle();
    end
    checkOutput("to abort s_read", 32'(s_read_o), 32'd0);
    checkOutput("to abort m1_ready", 32'(m1_ready_o), 32'd1);
    checkOutput("to abort m1_err", 32'(m1_err_o), 32'd1);
    checkOutput("to abort m1_data", m1_data_o, 32'd0);
    checkOutput("to abort m0_ready", 32'(m0_ready_o), 32'd0);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("to idle m1_ready", 32'(m1_ready_o), 32'd0);
    setTarget(1'b1, 32'hFF);
    checkOutput("late m1_ready", 32'(m1_ready_o), 32'd0);
    checkOutput("late m0_ready", 32'(m0_ready_o), 32'd0);
    checkOutput("late m1_data", m1_data_o, 32'd0);
    waitCycle();
    setTarget(1'b0, 32'h0);
    checkOutput("late s_read", 32'(s_read_o), 32'd0);

    // Target answers in the cycle the counter expires: completion wins
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    for (int k = 0; k < 7; k++) begin
      checkOutput($sformatf("edge s_write[%0d]", k), 32'(s_write_o), 32'd1);
      waitCycle();
    end
    setTarget(1'b1, 32'hBE);
    checkOutput("edge m0_ready", 32'(m0_ready_o), 32'd1);
    checkOutput("edge m0_err", 32'(m0_err_o), 32'd0);
    checkOutput("edge m0_data", m0_data_o, 32'hBE);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    setTarget(1'b0, 32'h0);
    checkOutput("edge after m0_ready", 32'(m0_ready_o), 32'd0);
    checkOutput("edge after m0_err", 32'(m0_err_o), 32'd0);

    // Reset in the middle of a transaction clears outputs immediately
    applyStimulus(1'b1, 1'b0, 32'h33, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    checkOutput("mid s_read", 32'(s_read_o), 32'd1);
    setTarget(1'b1, 32'h99);
    checkOutput("mid m0_ready", 32'(m0_ready_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid rst s_read", 32'(s_read_o), 32'd0);
    checkOutput("mid rst s_addr", s_addr_o, 32'd0);
    checkOutput("mid rst m0_ready", 32'(m0_ready_o), 32'd0);
    checkOutput("mid rst m0_data", m0_data_o, 32'd0);
    setTarget(1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    rst_ni = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    waitCycle();
    checkOutput("post rst s_addr", s_addr_o, 32'h100);
    setTarget(1'b1, 32'h5);
    checkOutput("post rst m0_ready", 32'(m0_ready_o), 32'd1);
    checkOutput("post rst m1_ready", 32'(m1_ready_o), 32'd0);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    setTarget(1'b0, 32'h0);

    // Read and write together from one master: write wins
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h5A, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    checkOutput("rw s_write", 32'(s_write_o), 32'd1);
    checkOutput("rw s_read", 32'(s_read_o), 32'd0);
    checkOutput("rw s_data", s_data_o, 32'h5A);
    setTarget(1'b1, 32'h0);
    checkOutput("rw m0_ready", 32'(m0_ready_o), 32'd1);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    setTarget(1'b0, 32'h0);
    checkOutput("rw done s_write", 32'(s_write_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
